// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the UART TX device: register map, bit positions, FSM states.
// Pure declarations, no logic or timing of its own.
package uart_tx_dev_pkg;

  localparam logic [1:0] UART_CTRL   = 2'd0;
  localparam logic [1:0] UART_STAT   = 2'd1;
  localparam logic [1:0] UART_TXDATA = 2'd2;
  localparam logic [1:0] UART_BAUD   = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int STAT_BUSY = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_DONE = 3;
  localparam int STAT_OVF  = 4;

  localparam logic [15:0] BAUD_MIN = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [15:0] clamp_baud(input logic [15:0] v);
    return (v < BAUD_MIN) ? BAUD_MIN : v;
  endfunction

endpackage

// File: rtl/uart_tx_dev_if.sv
// Bridge device-bus bundle: register select, write strobe/data, read data, level IRQ.
// Zero-latency read path; writes are single-cycle strobes with no backpressure.
interface uart_tx_dev_if;
  logic [1:0]  add;
  logic        we;
  logic [31:0] wr_dat;
  logic [31:0] rd_dat;
  logic        irq;

  modport master (output add, we, wr_dat, input rd_dat, irq);
  modport slave  (input add, we, wr_dat, output rd_dat, irq);
endinterface

// File: rtl/dev_fifo.sv
// Generic synchronous FIFO for bridge devices; read data valid while !empty, 1-cycle push-to-visible.
// Push while full is accepted only if a pop happens in the same cycle; pops on empty are ignored.
module dev_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Bridge-attached 8N1 UART transmitter: register file, TX FIFO, serialiser FSM, level IRQ.
// Push->pop 1 cycle, frame 10*BAUD cycles + 1 idle; a push into a full FIFO is dropped and flags OVF.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_dev_if.slave  bus,
  output logic          txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        ctrl_en, ctrl_ie, done, ovf, irq_q;
  logic [15:0] baud;
  tx_state_t   state, state_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [15:0] div_q, div_nxt, timer, timer_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic        pop, frame_done, tick;

  logic          push_req, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  assign push_req = bus.we && (bus.add == UART_TXDATA);
  assign tick     = (timer == div_q - 16'd1);

  dev_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (bus.wr_dat[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    div_nxt     = div_q;
    timer_nxt   = timer + 16'd1;
    bit_idx_nxt = bit_idx;
    pop         = 1'b0;
    frame_done  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        timer_nxt = '0;
        if (ctrl_en && !fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          div_nxt   = baud;
          state_nxt = ST_START;
        end
      end
      ST_START: if (tick) begin
        timer_nxt   = '0;
        bit_idx_nxt = '0;
        state_nxt   = ST_DATA;
      end
      ST_DATA: if (tick) begin
        timer_nxt   = '0;
        shift_nxt   = shift >> 1;
        bit_idx_nxt = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_nxt = ST_STOP;
      end
      ST_STOP: if (tick) begin
        timer_nxt  = '0;
        frame_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shift   <= '0;
      div_q   <= BAUD_MIN;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      div_q   <= div_nxt;
      timer   <= timer_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  // Sticky flags: a same-cycle set overrides a software clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_en <= 1'b0;
      ctrl_ie <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      irq_q   <= 1'b0;
      baud    <= BAUD_DIV_RST;
    end else begin
      irq_q <= ctrl_ie && done;
      if (bus.we && bus.add == UART_CTRL) begin
        ctrl_en <= bus.wr_dat[CTRL_EN];
        ctrl_ie <= bus.wr_dat[CTRL_IE];
      end
      if (bus.we && bus.add == UART_BAUD) baud <= clamp_baud(bus.wr_dat[15:0]);
      if (bus.we && bus.add == UART_STAT) begin
        if (bus.wr_dat[STAT_DONE]) done <= 1'b0;
        if (bus.wr_dat[STAT_OVF])  ovf  <= 1'b0;
      end
      if (frame_done) done <= 1'b1;
      if (push_req && fifo_full && !pop) ovf <= 1'b1;
    end
  end

  always_comb begin
    bus.rd_dat = '0;
    unique case (bus.add)
      UART_CTRL: begin
        bus.rd_dat[CTRL_EN] = ctrl_en;
        bus.rd_dat[CTRL_IE] = ctrl_ie;
      end
      UART_STAT: begin
        bus.rd_dat[STAT_BUSY]  = (state != ST_IDLE);
        bus.rd_dat[STAT_FULL]  = fifo_full;
        bus.rd_dat[STAT_EMPTY] = fifo_empty;
        bus.rd_dat[STAT_DONE]  = done;
        bus.rd_dat[STAT_OVF]   = ovf;
      end
      UART_TXDATA: bus.rd_dat = 32'(fifo_count);
      UART_BAUD:   bus.rd_dat = {16'd0, baud};
      default:     bus.rd_dat = '0;
    endcase
  end

  assign bus.irq = irq_q;
  assign txd     = (state == ST_START) ? 1'b0 :
                   (state == ST_DATA)  ? shift[0] : 1'b1;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Randomised bench for uart_tx_dev against a frame-time reference model.
module tb_uart_tx_dev;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic txd;

  uart_tx_dev_if bus();

  uart_tx_dev #(.FIFO_DEPTH(DEPTH), .BAUD_DIV_RST(16'd434)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is described only by its byte, divisor and elapsed cycles.
  logic [7:0] mq[$];
  bit         m_en, m_ie, m_done, m_ovf, m_irq, m_act;
  logic [7:0] m_byte;
  int         m_baud, m_div, m_t;

  function automatic logic m_txd();
    int k;
    if (!m_act) return 1'b1;
    k = m_t / m_div;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return {30'd0, m_ie, m_en};
      2'd1: return {27'd0, m_ovf, m_done, mq.size() == 0, mq.size() == DEPTH, m_act};
      2'd2: return 32'(mq.size());
      default: return 32'(m_baud);
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
    bit pop, fin, ovf_set;
    int old_baud;
    if (!r) begin
      mq.delete();
      m_en = 0; m_ie = 0; m_done = 0; m_ovf = 0; m_irq = 0; m_act = 0;
      m_baud = 434; m_t = 0;
      return;
    end
    pop      = !m_act && m_en && (mq.size() > 0);
    fin      = m_act && (m_t == 10 * m_div - 1);
    old_baud = m_baud;
    ovf_set  = 0;
    m_irq    = m_ie && m_done;
    if (fin) m_act = 0;
    else if (m_act) m_t++;
    if (pop) begin
      m_byte = mq.pop_front();
      m_div  = old_baud;
      m_t    = 0;
      m_act  = 1;
    end
    if (w && a == 2'd2) begin
      if (mq.size() < DEPTH) mq.push_back(d[7:0]);
      else ovf_set = 1;
    end
    if (w && a == 2'd1) begin
      if (d[3]) m_done = 0;
      if (d[4]) m_ovf = 0;
    end
    if (fin) m_done = 1;
    if (ovf_set) m_ovf = 1;
    if (w && a == 2'd0) begin
      m_en = d[0];
      m_ie = d[1];
    end
    if (w && a == 2'd3) m_baud = (d[15:0] < 2) ? 2 : int'(d[15:0]);
  endtask

  task automatic step(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
    rst_n      = r;
    bus.we     = w;
    bus.add    = a;
    bus.wr_dat = d;
    @(posedge clk);
    model_edge(r, w, a, d);
    @(negedge clk);
    bus.we = 1'b0;
    rst_n  = 1'b1;
    chk("txd", 32'(txd), 32'(m_txd()));
    chk("irq", 32'(bus.irq), 32'(m_irq));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, bus.add, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1, 1, a, d);
  endtask

  task automatic rd(input string tag, input logic [1:0] a);
    bus.add = a;
    #1;
    chk(tag, bus.rd_dat, m_read(a));
  endtask

  // Advance until the model sits at elapsed time t_of(k) inside an active frame.
  task automatic wait_frame_t(input string tag, input bool_end, input int bit_slot);
    bit hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (m_act && ((bool_end && m_t == 10 * m_div - 1) || (!bool_end && m_t == bit_slot * m_div)))
        hit = 1;
      else
        idle(1);
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    bus.we = 1'b0; bus.add = 2'd0; bus.wr_dat = '0;
    @(negedge clk);

    // Reset values
    step(0, 0, 2'd0, 0);
    step(0, 0, 2'd0, 0);
    rd("rst_ctrl", 2'd0);  chk("rst_ctrl_c", bus.rd_dat, 32'd0);
    rd("rst_stat", 2'd1);  chk("rst_stat_c", bus.rd_dat, 32'h4);
    rd("rst_cnt", 2'd2);   chk("rst_cnt_c", bus.rd_dat, 32'd0);
    rd("rst_baud", 2'd3);  chk("rst_baud_c", bus.rd_dat, 32'd434);

    // Single 0x55 frame at divisor 4 with IRQ
    wr(2'd3, 4); wr(2'd0, 3); wr(2'd2, 32'h55);
    idle(44);
    rd("t2_stat", 2'd1);   chk("t2_done", 32'(bus.rd_dat[3]), 32'd1);
    chk("t2_irq", 32'(bus.irq), 32'd1);

    // Fill while disabled, overflow, then drain in order
    wr(2'd0, 0); wr(2'd1, 32'h18);
    for (int i = 0; i < 5; i++) wr(2'd2, 32'h11 + i);
    rd("t3_cnt", 2'd2);    chk("t3_cnt_c", bus.rd_dat, 32'd4);
    rd("t3_stat", 2'd1);   chk("t3_full_ovf", bus.rd_dat & 32'h12, 32'h12);
    wr(2'd1, 32'h10);
    wr(2'd0, 1);
    wr(2'd2, 32'h99);   // push on the same edge as the first pop while full
    rd("t3_cnt2", 2'd2);   chk("t3_cnt2_c", bus.rd_dat, 32'd4);
    rd("t3_ovf2", 2'd1);   chk("t3_ovf2_c", 32'(bus.rd_dat[4]), 32'd0);
    idle(5 * 41 + 4);
    rd("t3_end", 2'd1);

    // Baud clamp and mid-frame baud change
    wr(2'd3, 1);
    rd("t4_baud", 2'd3);   chk("t4_baud_c", bus.rd_dat, 32'd2);
    wr(2'd3, 4); wr(2'd2, 32'hA5); wr(2'd2, 32'h3C);
    idle(10); wr(2'd3, 8);
    idle(45 + 81 + 4);
    rd("t4_stat", 2'd1);

    // EN cleared mid-frame, then reset mid-frame
    wr(2'd3, 4); wr(2'd2, 32'h77); wr(2'd2, 32'h88);
    wait_frame_t("t5_wait_bit3", 0, 4);
    wr(2'd0, 0);
    idle(40);
    rd("t5_cnt", 2'd2);    chk("t5_cnt_c", bus.rd_dat, 32'd1);
    wr(2'd0, 1);
    idle(12);
    step(0, 0, 2'd1, 0);
    chk("t5_rst_txd", 32'(txd), 32'd1);
    rd("t5_rst_stat", 2'd1); chk("t5_rst_stat_c", bus.rd_dat, 32'h4);

    // DONE clear, IRQ drop, clear coinciding with frame end
    wr(2'd3, 2); wr(2'd0, 3); wr(2'd2, 32'hC3);
    idle(25);
    wr(2'd1, 32'h8);
    idle(2);
    rd("t6_clr", 2'd1);    chk("t6_irq_low", 32'(bus.irq), 32'd0);
    wr(2'd2, 32'h5A);
    wait_frame_t("t6_wait_end", 1, 0);
    wr(2'd1, 32'h8);
    rd("t6_race", 2'd1);   chk("t6_race_c", 32'(bus.rd_dat[3]), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30)      wr(2'd2, 32'($urandom_range(0, 255)));
      else if (r < 35) wr(2'd0, 32'($urandom_range(0, 3)) | 32'd1);
      else if (r < 37) wr(2'd0, 32'($urandom_range(0, 3)));
      else if (r < 41) wr(2'd3, 32'($urandom_range(0, 5)));
      else if (r < 45) wr(2'd1, 32'($urandom));
      else if (r < 52) rd("rnd_rd", 2'($urandom_range(0, 3)));
      else if (r < 53) step(0, 0, 2'd0, 0);
      else             idle(1);
    end
    for (int a = 0; a < 4; a++) rd("final_rd", 2'(a));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
